bpsk_stim_gen: RTL and testbench
================================

// Module: bpsk_stim_gen
// PURPOSE
//  Synthesizable, parametrised BPSK test-signal source for demodulator bring-up, on-chip and in simulation.
//  Drives a phase-accumulator angle into one cosine_lut read port, then applies BPSK symbol sign to the returned sample.
//  Programmable carrier step, initial phase offset, symbol rate, preamble and PRBS payload length.
//  Output feeds bpsk_demodulator_top.data_in directly.
// PARAMETERS
//  DATA_WIDTH     `FIXDT_24_WIDTH                       sample width, signed fixed point
//  PHASE_WIDTH    $clog2(`CARRIER_SAMPLES_PER_PERIOD)   LUT angle width; accumulator wraps mod 2^PHASE_WIDTH
//  SPS_WIDTH      16                                    width of samples-per-symbol config
//  NSYM_WIDTH     16                                    width of payload symbol count
//  PREAMBLE_SYMS  32                                    alternating 1/0 preamble length (0 = no preamble)
//  LFSR_SEED      15'h7ACE                              PRBS15 seed, must be nonzero
//  LUT_LATENCY    1                                     cycles from lu_angle to lut_cos
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            synchronous, active-low reset
//  en           in   1            clock enable; low = all state holds
//  start        in   1            1-cycle pulse, honoured in IDLE only
//  abort        in   1            return to IDLE, flush pipeline
//  cfg_phase0   in   PHASE_WIDTH  initial phase offset (steps)
//  cfg_step     in   PHASE_WIDTH  phase increment per sample
//  cfg_sps      in   SPS_WIDTH    samples per symbol (0 treated as 1)
//  cfg_nsym     in   NSYM_WIDTH   payload symbols (0 = preamble only)
//  lu_angle     out  PHASE_WIDTH  to cosine_lut read port
//  lut_cos      in   DATA_WIDTH   signed LUT result, LUT_LATENCY after lu_angle
//  sample_out   out  DATA_WIDTH   signed BPSK sample
//  sample_valid out  1            sample_out valid
//  sym_out      out  1            symbol aligned with sample_out
//  busy         out  1            state != IDLE
//  done         out  1            1-cycle pulse at end of burst
// BEHAVIOUR
//  - Reset: FSM=IDLE, acc=0, LFSR=LFSR_SEED, lu_angle=0, sample_out=0, sample_valid=0, sym_out=0, busy=0, done=0.
//  - FSM: IDLE -start-> PRE (if PREAMBLE_SYMS>0) else PAY; PRE -last preamble sample-> PAY (cfg_nsym>0) else DONE.
//    PAY -last payload sample-> DONE; DONE -> IDLE after 1 cycle; done=1 only in DONE.
//  - On start: latch all cfg_*; set acc=cfg_phase0; load symbol sample counter with sps-1; reset LFSR to seed.
//  - Active cycle (en=1, PRE/PAY): lu_angle=acc, acc<=acc+cfg_step, mod 2^PHASE_WIDTH.
//  - Each active cycle issues exactly one angle. Counter decrements; at 0 it reloads and the next symbol starts.
//  - Preamble symbols: 1,0,1,0,... starting with 1. Payload symbols: PRBS15 (x^15+x^14+1) LFSR output bit.
//    LFSR advances once per payload symbol.
//  - Symbol/valid tag delayed LUT_LATENCY through a shift register, aligned to lut_cos.
//    sample_out=sym? -lut_cos : lut_cos, registered (+1 cycle). Total latency angle->sample = LUT_LATENCY+1.
//  - Negation of most-negative value saturates to most-positive; no other width growth.
//  - Outside active states, sample_valid=0 and sample_out holds its last value.
//  - Pipeline drains after the last angle; valid tail finishes before done is asserted.
//  - en=0: accumulator, counters, FSM and delay line all freeze; sample_valid forced 0 for that cycle.
//  - start while busy: ignored. start and abort in the same cycle: abort wins.
//  - abort (any state, even en=0): next cycle IDLE, delay line valid bits cleared, no done pulse.
//  - Burst length in samples = (PREAMBLE_SYMS+cfg_nsym)*max(cfg_sps,1).
// CONFIGURATION
//  - `BPSK_STIM_DIFF_EN defined: payload bits are differentially encoded before sign mapping.
//    Rule: tx = tx_prev ^ prbs. tx_prev is initialised to the last preamble symbol (or 0 if no preamble).
//    sym_out carries the encoded bit.
//  - Undefined: payload sign = raw PRBS bit; no encoder register is synthesized.
// TESTING
//  - Reset, then idle 20 cycles -> sample_valid=0, busy=0, lu_angle=0, sample_out=0.
//  - phase0=5235, step=CARRIER_SAMPLES_PER_PERIOD/(SAMPLING_FREQ/CARRIER_FREQ), sps=`SAMPLES_PER_SYMBOL, nsym=0:
//    first lu_angle=5235; 32 preamble symbols alternate sign; done pulses once.
//  - Wrap: phase0=2^PHASE_WIDTH-1, step=2 -> lu_angle sequence max, 1, 3, ...
//  - nsym=100, sps=4 -> exactly (32+100)*4 valid samples; sym_out matches the PRBS15 model from the seed.
//  - lut_cos=-2^(DATA_WIDTH-1) with sym=1 -> sample_out=2^(DATA_WIDTH-1)-1.
//  - abort mid-payload -> valid=0 next cycle, no done; a new start replays an identical sequence.
//    en toggled 50% -> same sample sequence as en=1.

Source files
------------

// File: rtl/bpsk_stim_gen.sv
// BPSK test-signal source: phase accumulator -> cosine LUT port -> symbol sign, with preamble and PRBS15 payload.
// Optional `BPSK_STIM_DIFF_EN: differential encoding of payload bits (tx = tx_prev ^ prbs).
`ifndef FIXDT_24_WIDTH
`define FIXDT_24_WIDTH 24
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 8192
`endif

module bpsk_stim_gen #(
  parameter int          DATA_WIDTH    = `FIXDT_24_WIDTH,
  parameter int          PHASE_WIDTH   = $clog2(`CARRIER_SAMPLES_PER_PERIOD),
  parameter int          SPS_WIDTH     = 16,
  parameter int          NSYM_WIDTH    = 16,
  parameter int          PREAMBLE_SYMS = 32,
  parameter logic [14:0] LFSR_SEED     = 15'h7ACE,
  parameter int          LUT_LATENCY   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         start,
  input  logic                         abort,
  input  logic [PHASE_WIDTH-1:0]       cfg_phase0,
  input  logic [PHASE_WIDTH-1:0]       cfg_step,
  input  logic [SPS_WIDTH-1:0]         cfg_sps,
  input  logic [NSYM_WIDTH-1:0]        cfg_nsym,
  output logic [PHASE_WIDTH-1:0]       lu_angle,
  input  logic signed [DATA_WIDTH-1:0] lut_cos,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_valid,
  output logic                         sym_out,
  output logic                         busy,
  output logic                         done
);
  localparam int PRE_W = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_PAY, S_DRAIN, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [PHASE_WIDTH-1:0]       acc_reg, step_reg;
  logic [SPS_WIDTH-1:0]         sps_reg, cnt_reg, sps_eff;
  logic [NSYM_WIDTH-1:0]        pay_left_reg;
  logic                         pay_zero_reg;
  logic [PRE_W-1:0]             pre_left_reg;
  logic                         pre_sym_reg;
  logic [14:0]                  lfsr_reg;
  logic [LUT_LATENCY-1:0]       vld_sr, sym_sr;
  logic                         active, sym_end, sym_cur, pay_sym, start_ok;
  logic signed [DATA_WIDTH-1:0] neg_cos;
  logic signed [DATA_WIDTH-1:0] sample_reg;
  logic                         valid_reg, sym_out_reg;

  assign sps_eff  = (cfg_sps == '0) ? SPS_WIDTH'(1) : cfg_sps;
  assign active   = en && (state_reg == S_PRE || state_reg == S_PAY);
  assign sym_end  = (cnt_reg == '0);
  assign start_ok = en && start && (state_reg == S_IDLE);

`ifdef BPSK_STIM_DIFF_EN
  logic tx_prev_reg;
  assign pay_sym = tx_prev_reg ^ lfsr_reg[14];
  // Encoder history starts from the last preamble symbol (alternation starting at 1).
  always_ff @(posedge clk) begin
    if (!rst_n)
      tx_prev_reg <= 1'b0;
    else if (start_ok && !abort)
      tx_prev_reg <= 1'(PREAMBLE_SYMS % 2);
    else if (active && !abort && state_reg == S_PAY && sym_end)
      tx_prev_reg <= pay_sym;
  end
`else
  assign pay_sym = lfsr_reg[14];
`endif

  assign sym_cur = (state_reg == S_PRE) ? pre_sym_reg : pay_sym;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_ok)
                 state_next = (PREAMBLE_SYMS > 0) ? S_PRE :
                              ((cfg_nsym != '0) ? S_PAY : S_DRAIN);
      S_PRE:   if (active && sym_end && pre_left_reg == '0)
                 state_next = pay_zero_reg ? S_DRAIN : S_PAY;
      S_PAY:   if (active && sym_end && pay_left_reg == '0)
                 state_next = S_DRAIN;
      // Hold off done until the last tagged sample has left the delay line.
      S_DRAIN: if (en && vld_sr == '0) state_next = S_DONE;
      S_DONE:  if (en) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg      <= '0;
      step_reg     <= '0;
      sps_reg      <= SPS_WIDTH'(1);
      cnt_reg      <= '0;
      pay_left_reg <= '0;
      pay_zero_reg <= 1'b1;
      pre_left_reg <= '0;
      pre_sym_reg  <= 1'b1;
      lfsr_reg     <= LFSR_SEED;
    end else if (start_ok && !abort) begin
      acc_reg      <= cfg_phase0;
      step_reg     <= cfg_step;
      sps_reg      <= sps_eff;
      cnt_reg      <= sps_eff - 1'b1;
      pay_left_reg <= cfg_nsym - 1'b1;
      pay_zero_reg <= (cfg_nsym == '0);
      pre_left_reg <= PRE_W'(PREAMBLE_SYMS - 1);
      pre_sym_reg  <= 1'b1;
      lfsr_reg     <= LFSR_SEED;
    end else if (active && !abort) begin
      acc_reg <= acc_reg + step_reg;
      if (sym_end) begin
        cnt_reg <= sps_reg - 1'b1;
        if (state_reg == S_PRE) begin
          pre_left_reg <= pre_left_reg - 1'b1;
          pre_sym_reg  <= ~pre_sym_reg;
        end else begin
          pay_left_reg <= pay_left_reg - 1'b1;
          lfsr_reg     <= {lfsr_reg[13:0], lfsr_reg[14] ^ lfsr_reg[13]};
        end
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  // Tag line assumes the LUT read port shares this clock enable, so both freeze together.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      vld_sr <= '0;
      sym_sr <= '0;
    end else if (en) begin
      vld_sr <= (vld_sr << 1) | LUT_LATENCY'(active);
      sym_sr <= (sym_sr << 1) | LUT_LATENCY'(sym_cur);
    end
  end

  assign neg_cos = (lut_cos == S_MIN) ? S_MAX : -lut_cos;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_reg  <= '0;
      valid_reg   <= 1'b0;
      sym_out_reg <= 1'b0;
    end else if (abort || !en) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= vld_sr[LUT_LATENCY-1];
      if (vld_sr[LUT_LATENCY-1]) begin
        sample_reg  <= sym_sr[LUT_LATENCY-1] ? neg_cos : lut_cos;
        sym_out_reg <= sym_sr[LUT_LATENCY-1];
      end
    end
  end

  assign lu_angle     = acc_reg;
  assign sample_out   = sample_reg;
  assign sample_valid = valid_reg;
  assign sym_out      = sym_out_reg;
  assign busy         = (state_reg != S_IDLE);
  assign done         = (state_reg == S_DONE);
endmodule

// File: tb/tb_bpsk_stim_gen.sv
// Directed bench for bpsk_stim_gen: table of bursts checked against a sample-level model, plus abort/wrap/saturation sequences.
`ifndef FIXDT_24_WIDTH
`define FIXDT_24_WIDTH 24
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 8192
`endif
`ifndef SAMPLING_FREQ
`define SAMPLING_FREQ 80000000
`endif
`ifndef CARRIER_FREQ
`define CARRIER_FREQ 10000000
`endif
`ifndef SAMPLES_PER_SYMBOL
`define SAMPLES_PER_SYMBOL 8
`endif

module tb_bpsk_stim_gen;
  localparam int DW       = `FIXDT_24_WIDTH;
  localparam int PW       = $clog2(`CARRIER_SAMPLES_PER_PERIOD);
  localparam int NPRE     = 32;
  localparam int SPS_DEF  = `SAMPLES_PER_SYMBOL;
  localparam int STEP_DEF = `CARRIER_SAMPLES_PER_PERIOD / (`SAMPLING_FREQ / `CARRIER_FREQ);
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};

  typedef struct {
    logic [PW-1:0] phase0;
    logic [PW-1:0] step;
    logic [15:0]   sps;
    logic [15:0]   nsym;
    bit            toggle;
    bit            mid_start;
    bit            sat;
    int            exp_len;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [PW-1:0] cfg_phase0 = '0, cfg_step = '0, lu_angle;
  logic [15:0] cfg_sps = '0, cfg_nsym = '0;
  logic signed [DW-1:0] lut_cos = '0, sample_out;
  logic sample_valid, sym_out, busy, done;

  bit force_min = 1'b0;
  int n_checks = 0, n_pass = 0;
  bit pay_bits [256];
  logic signed [DW-1:0] got_samp [1024];
  logic [PW-1:0] got_ang [3];
  vec_t vecs [7];

  always #5 clk = ~clk;

  bpsk_stim_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .abort(abort),
    .cfg_phase0(cfg_phase0), .cfg_step(cfg_step), .cfg_sps(cfg_sps), .cfg_nsym(cfg_nsym),
    .lu_angle(lu_angle), .lut_cos(lut_cos), .sample_out(sample_out),
    .sample_valid(sample_valid), .sym_out(sym_out), .busy(busy), .done(done)
  );

  // Stand-in LUT: distinct value per angle, registered read sharing the system clock enable.
  function automatic logic signed [DW-1:0] lut_fn(input logic [PW-1:0] a);
    if (force_min) return SMIN;
    return $signed({a, {(DW-PW){1'b1}}});
  endfunction

  always @(posedge clk) if (en) lut_cos <= lut_fn(lu_angle);

  function automatic vec_t mk(input int p0, input int st, input int sps, input int nsym,
                              input bit tg, input bit ms, input bit sat);
    vec_t v;
    int se;
    se = (sps == 0) ? 1 : sps;
    v.phase0 = PW'(p0); v.step = PW'(st); v.sps = 16'(sps); v.nsym = 16'(nsym);
    v.toggle = tg; v.mid_start = ms; v.sat = sat; v.exp_len = (NPRE + nsym) * se;
    return v;
  endfunction

  function automatic bit exp_sym(input vec_t v, input int n);
    int s, k;
    s = (v.sps == 0) ? 1 : int'(v.sps);
    k = n / s;
    if (k < NPRE) return (k % 2) == 0;
    return pay_bits[k - NPRE];
  endfunction

  function automatic logic signed [DW-1:0] exp_val(input vec_t v, input int n);
    logic [PW-1:0] a;
    logic signed [DW-1:0] x;
    a = PW'((int'(v.phase0) + n * int'(v.step)) % (1 << PW));
    x = lut_fn(a);
    if (!exp_sym(v, n)) return x;
    return (x == SMIN) ? SMAX : -x;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, req);
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    int n, mism, done_edges, en0_bad, first_bad;
    bit prev_done;
    n = 0; mism = 0; done_edges = 0; en0_bad = 0; first_bad = -1; prev_done = 1'b0;
    cfg_phase0 = v.phase0; cfg_step = v.step; cfg_sps = v.sps; cfg_nsym = v.nsym;
    force_min = v.sat;
    en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 4000 && busy; cyc++) begin
      if (cyc == 0) check({tag, ".first_angle"}, lu_angle, v.phase0);
      if (cyc < 3) got_ang[cyc] = lu_angle;
      if (sample_valid) begin
        if (!en) en0_bad++;
        if (n < 1024) got_samp[n] = sample_out;
        if (sample_out !== exp_val(v, n) || sym_out !== exp_sym(v, n)) begin
          mism++;
          if (first_bad < 0) first_bad = n;
        end
        n++;
      end
      if (done && !prev_done) done_edges++;
      prev_done = done;
      start = v.mid_start && (cyc == 20);
      en = v.toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; en = 1'b1;
    check({tag, ".ended"}, busy, 0);
    check({tag, ".len"}, n, v.exp_len);
    check({tag, ".seq_errors"}, mism, 0);
    check({tag, ".done_pulses"}, done_edges, 1);
    check({tag, ".valid_after_en0"}, en0_bad, 0);
    $display("burst %s: %0d samples, first bad index %0d", tag, n, first_bad);
    force_min = 1'b0;
  endtask

  initial begin
    logic [14:0] st;
    bit prev;
    int n, dcnt, vcnt;

    st = 15'h7ACE;
    prev = (NPRE % 2) == 1;
    for (int k = 0; k < 256; k++) begin
`ifdef BPSK_STIM_DIFF_EN
      prev = prev ^ st[14];
      pay_bits[k] = prev;
`else
      pay_bits[k] = st[14];
`endif
      st = {st[13:0], st[14] ^ st[13]};
    end

    vecs[0] = mk(5235, STEP_DEF, SPS_DEF, 0, 0, 0, 0);
    vecs[1] = mk((1 << PW) - 1, 2, 1, 0, 0, 0, 0);
    vecs[2] = mk(0, 3, 4, 100, 0, 0, 0);
    vecs[3] = mk(100, 7, 0, 5, 0, 1, 0);
    vecs[4] = mk(5235, STEP_DEF, 3, 10, 1, 0, 0);
    vecs[5] = mk(1, (1 << PW) - 1, 2, 1, 0, 1, 0);
    vecs[6] = mk(0, 1, 1, 2, 0, 0, 1);

    rst_n = 1'b0; en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("reset.valid", sample_valid, 0);
    check("reset.busy", busy, 0);
    check("reset.angle", lu_angle, 0);
    check("reset.sample", sample_out, 0);
    check("reset.done", done, 0);
    check("reset.sym", sym_out, 0);

    for (int i = 0; i < 7; i++) begin
      run_burst(vecs[i], $sformatf("vec%0d", i));
      if (i == 1) begin
        check("wrap.angle0", got_ang[0], (1 << PW) - 1);
        check("wrap.angle1", got_ang[1], 1);
        check("wrap.angle2", got_ang[2], 3);
      end
      if (vecs[i].sat) begin
        check("sat.neg_min", got_samp[0], SMAX);
        check("sat.pos_min", got_samp[1], SMIN);
      end
      repeat (3) @(posedge clk);
      #1;
    end

    // Abort in the payload with en low, then replay the same burst.
    cfg_phase0 = vecs[2].phase0; cfg_step = vecs[2].step;
    cfg_sps = vecs[2].sps; cfg_nsym = vecs[2].nsym;
    en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 2000 && n < 200; cyc++) begin
      if (sample_valid) n++;
      @(posedge clk); #1;
    end
    check("abort.reached_payload", n, 200);
    en = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; en = 1'b1;
    check("abort.valid", sample_valid, 0);
    check("abort.busy", busy, 0);
    dcnt = 0; vcnt = 0;
    repeat (10) begin
      if (done) dcnt++;
      if (sample_valid) vcnt++;
      @(posedge clk); #1;
    end
    check("abort.no_done", dcnt, 0);
    check("abort.no_valid", vcnt, 0);
    $display("abort after %0d samples", n);
    run_burst(vecs[2], "replay");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
